// File: rtl/periph_bus_master_if.sv
// Command, response and peripheral strobe signals of the
// peripheral bus initiator, bundled with master/slave views.
interface periph_bus_master_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  cmdValid;
    logic                  cmdReady;
    logic                  cmdWrite;
    logic [DATA_WIDTH-1:0] cmdData;
    logic                  rspValid;
    logic                  rspReady;
    logic [DATA_WIDTH-1:0] rspData;
    logic                  rspTimeout;
    logic                  read;
    logic                  write;
    logic [DATA_WIDTH-1:0] dataOut;
    logic [DATA_WIDTH-1:0] dataIn;
    logic                  readValid;

    modport master (
        input  cmdValid,
        input  cmdWrite,
        input  cmdData,
        input  rspReady,
        input  dataIn,
        input  readValid,
        output cmdReady,
        output rspValid,
        output rspData,
        output rspTimeout,
        output read,
        output write,
        output dataOut
    );

    modport slave (
        output cmdValid,
        output cmdWrite,
        output cmdData,
        output rspReady,
        output dataIn,
        output readValid,
        input  cmdReady,
        input  rspValid,
        input  rspData,
        input  rspTimeout,
        input  read,
        input  write,
        input  dataOut
    );
endinterface

// File: rtl/periph_bus_master.sv
// Single-outstanding initiator for the one-cycle read/write
// peripheral strobe bus, with a bounded wait for read data.
module periph_bus_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    periph_bus_master_if.master bus
);
    localparam int CW =
        (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WSTB,
        RSTB,
        WAIT,
        RESP
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            bus.cmdReady   <= 1'b0;
            bus.read       <= 1'b0;
            bus.write      <= 1'b0;
            bus.rspValid   <= 1'b0;
            bus.rspTimeout <= 1'b0;
            bus.dataOut    <= {DATA_WIDTH{1'b0}};
            bus.rspData    <= {DATA_WIDTH{1'b0}};
        end else begin
            unique case (state)
                IDLE: begin
                    bus.cmdReady <= 1'b1;
                    if (bus.cmdReady && bus.cmdValid) begin
                        bus.cmdReady <= 1'b0;
                        if (bus.cmdWrite) begin
                            state       <= WSTB;
                            bus.write   <= 1'b1;
                            bus.dataOut <= bus.cmdData;
                        end else begin
                            state    <= RSTB;
                            bus.read <= 1'b1;
                        end
                    end
                end
                WSTB: begin
                    state          <= RESP;
                    bus.write      <= 1'b0;
                    bus.rspValid   <= 1'b1;
                    bus.rspTimeout <= 1'b0;
                    bus.rspData    <= {DATA_WIDTH{1'b0}};
                end
                RSTB: begin
                    state    <= WAIT;
                    bus.read <= 1'b0;
                    wait_cnt <= '0;
                end
                WAIT: begin
                    // data arriving on the last count still beats the timeout
                    if (bus.readValid) begin
                        state          <= RESP;
                        bus.rspValid   <= 1'b1;
                        bus.rspTimeout <= 1'b0;
                        bus.rspData    <= bus.dataIn;
                    end else if (wait_cnt == LAST) begin
                        state          <= RESP;
                        bus.rspValid   <= 1'b1;
                        bus.rspTimeout <= 1'b1;
                        bus.rspData    <= {DATA_WIDTH{1'b0}};
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rspReady) begin
                        state        <= IDLE;
                        bus.rspValid <= 1'b0;
                        bus.cmdReady <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
